// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-clock divider, x/y raster counters, frame counter,
// and a sync/blank delay line so x/y lead the monitor-side signals by PIPE_DLY pixel ticks.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int PIX_DIV   = 1,
    parameter int PIPE_DLY  = 1,
    parameter int CW        = 10,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restart,
    output logic               p_tick,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic x_last;
    logic y_last;
    logic hs_raw;
    logic vs_raw;
    logic von_raw;
    logic hs_d;
    logic vs_d;
    logic von_d;

    generate
        if (PIX_DIV <= 1) begin : g_no_div
            assign p_tick = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(PIX_DIV);
            logic [DIV_W-1:0] div;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    div <= '0;
                end else if (restart || p_tick) begin
                    div <= '0;
                end else begin
                    div <= div + 1'b1;
                end
            end

            assign p_tick = (div == DIV_W'(PIX_DIV - 1));
        end
    endgenerate

    assign x_last = (x == CW'(H_TOTAL - 1));
    assign y_last = (y == CW'(V_TOTAL - 1));

    // restart clears the raster but keeps the frame count, and wins over a coincident wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
        end else if (restart) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y         <= '0;
                    frame_cnt <= frame_cnt + 1'b1;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign hs_raw  = (x >= CW'(HS_FIRST)) && (x <= CW'(HS_LAST));
    assign vs_raw  = (y >= CW'(VS_FIRST)) && (y <= CW'(VS_LAST));
    assign von_raw = (x < CW'(H_DISPLAY)) && (y < CW'(V_DISPLAY));

    // Stages hold active-high flags; polarity is applied only at the pins
    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            assign hs_d  = hs_raw;
            assign vs_d  = vs_raw;
            assign von_d = von_raw;
        end else begin : g_dly
            logic [2:0] stage [PIPE_DLY];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage[i] <= 3'b000;
                    end
                end else if (restart) begin
                    for (int i = 0; i < PIPE_DLY; i++) begin
                        stage[i] <= 3'b000;
                    end
                end else if (p_tick) begin
                    stage[0] <= {hs_raw, vs_raw, von_raw};
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign {hs_d, vs_d, von_d} = stage[PIPE_DLY-1];
        end
    endgenerate

    assign hsync       = hs_d ? HS_ACT : ~HS_ACT;
    assign vsync       = vs_d ? VS_ACT : ~VS_ACT;
    assign video_on    = von_d;
    assign line_start  = p_tick && (x == '0);
    assign frame_start = p_tick && (x == '0) && (y == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so whole frames and frame-counter wrap fit a short run.
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HSW = 3, HB = 2;
    localparam int VD = 6, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HD + HF + HSW + HB;
    localparam int VT = VD + VF + VSW + VB;
    localparam int PD = 2;
    localparam int DLY = 2;
    localparam int CW = 4;
    localparam int FW = 3;
    localparam logic HSP = 1'b1;
    localparam logic VSP = 1'b0;
    localparam int FRAME_CLK = HT * VT * PD;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [FW-1:0] fr;
        logic          pt;
        logic          ls;
        logic          fs;
        logic          hs;
        logic          vs;
        logic          von;
    } obs_t;

    localparam obs_t RESET_OBS = '{x: '0, y: '0, fr: '0, pt: 1'b0, ls: 1'b0, fs: 1'b0,
                                   hs: ~HSP, vs: ~VSP, von: 1'b0};

    logic          clk;
    logic          reset;
    logic          restart;
    logic          p_tick;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          line_start;
    logic          frame_start;
    logic [FW-1:0] frame_cnt;

    int   total;
    int   bad;
    int   cyc;
    int   fbase;
    obs_t exp_q[$];

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(1), .VS_POL(0), .PIX_DIV(PD), .PIPE_DLY(DLY), .CW(CW), .FRAME_W(FW)
    ) dut (
        .clk(clk), .reset(reset), .restart(restart), .p_tick(p_tick),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after cc clock edges since the last reset/restart, derived from tick arithmetic
    function automatic obs_t model(int cc, int fb);
        obs_t e;
        int n, pos, p, px, py;
        n      = cc / PD;
        pos    = n % (HT * VT);
        e.x    = CW'(pos % HT);
        e.y    = CW'(pos / HT);
        e.fr   = FW'((fb + n / (HT * VT)) % (1 << FW));
        e.pt   = (cc % PD) == PD - 1;
        e.ls   = e.pt && (pos % HT == 0);
        e.fs   = e.pt && (pos == 0);
        if (n < DLY) begin
            e.hs  = ~HSP;
            e.vs  = ~VSP;
            e.von = 1'b0;
        end else begin
            p     = (n - DLY) % (HT * VT);
            px    = p % HT;
            py    = p / HT;
            e.hs  = (px >= HD + HF && px < HD + HF + HSW) ? HSP : ~HSP;
            e.vs  = (py >= VD + VF && py < VD + VF + VSW) ? VSP : ~VSP;
            e.von = (px < HD) && (py < VD);
        end
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.x = x; o.y = y; o.fr = frame_cnt; o.pt = p_tick; o.ls = line_start;
        o.fs = frame_start; o.hs = hsync; o.vs = vsync; o.von = video_on;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d fr=%0d pt=%0b ls=%0b fs=%0b hs=%0b vs=%0b von=%0b",
                         o.x, o.y, o.fr, o.pt, o.ls, o.fs, o.hs, o.vs, o.von);
    endfunction

    // One clock: advance the model with the inputs the DUT samples, queue the expectation, settle
    task automatic clock_step();
        obs_t cur;
        @(posedge clk);
        if (reset) begin
            cyc   = 0;
            fbase = 0;
        end else if (restart) begin
            cur   = model(cyc, fbase);
            fbase = int'(cur.fr);
            cyc   = 0;
        end else begin
            cyc++;
        end
        exp_q.push_back(model(cyc, fbase));
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t got, e;
        reset = 1'b1; restart = 1'b0;
        #12;
        got = observe(); total++;
        if (got !== RESET_OBS) begin
            bad++; $display("FAIL reset_init got(%s) exp(%s)", fmt(got), fmt(RESET_OBS));
        end
        @(negedge clk); reset = 1'b0; cyc = 0; fbase = 0;
        repeat (PD * (HT * 5 + 7)) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL reset_run cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
        end
        #3 reset = 1'b1;
        #1 got = observe(); total++;
        if (got !== RESET_OBS) begin
            bad++; $display("FAIL reset_async got(%s) exp(%s)", fmt(got), fmt(RESET_OBS));
        end
        @(negedge clk); reset = 1'b0; cyc = 0; fbase = 0;
    endtask

    task automatic test_raster();
        obs_t got, e;
        int ls_n = 0, fs_n = 0, hs_n = 0, vs_n = 0, von_n = 0, last_ls = -1, gap_bad = 0;
        repeat (PD * 3) clock_step();
        exp_q.delete();
        for (int i = 0; i < FRAME_CLK; i++) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL raster cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
            if (line_start) begin
                if (last_ls >= 0 && i - last_ls != HT * PD) gap_bad++;
                last_ls = i; ls_n++;
            end
            if (frame_start) fs_n++;
            if (hsync == HSP) hs_n++;
            if (vsync == VSP) vs_n++;
            if (video_on) von_n++;
        end
        total++; if (ls_n !== VT) begin bad++; $display("FAIL line_count got=%0d exp=%0d", ls_n, VT); end
        total++; if (gap_bad !== 0) begin bad++; $display("FAIL line_period bad_gaps=%0d exp=0", gap_bad); end
        total++; if (fs_n !== 1) begin bad++; $display("FAIL frame_count got=%0d exp=1", fs_n); end
        total++; if (hs_n !== VT * HSW * PD) begin bad++; $display("FAIL hsync_clks got=%0d exp=%0d", hs_n, VT * HSW * PD); end
        total++; if (vs_n !== VSW * HT * PD) begin bad++; $display("FAIL vsync_clks got=%0d exp=%0d", vs_n, VSW * HT * PD); end
        total++; if (von_n !== VD * HD * PD) begin bad++; $display("FAIL video_clks got=%0d exp=%0d", von_n, VD * HD * PD); end
    endtask

    task automatic test_frame_wrap();
        obs_t got, e;
        int fs_n = 0;
        logic saw_wrap = 1'b0;
        logic [FW-1:0] prev_fr;
        prev_fr = frame_cnt;
        for (int i = 0; i < (1 << FW) * FRAME_CLK; i++) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL frame_wrap cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
            if (frame_start) fs_n++;
            if (prev_fr == '1 && frame_cnt == '0) saw_wrap = 1'b1;
            prev_fr = frame_cnt;
        end
        total++; if (fs_n !== (1 << FW)) begin bad++; $display("FAIL wrap_frames got=%0d exp=%0d", fs_n, 1 << FW); end
        total++; if (saw_wrap !== 1'b1) begin bad++; $display("FAIL wrap_seen got=%0b exp=1", saw_wrap); end
    endtask

    task automatic test_restart();
        obs_t got, e, cur;
        logic [FW-1:0] held;
        int found = 0, first_fs = -1, second_fs = -1;
        repeat (PD * (HT * 4 + 5) + 1) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL restart_pre cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
        end
        cur = model(cyc, fbase); held = cur.fr;
        restart = 1'b1; clock_step(); restart = 1'b0;
        got = observe(); e = exp_q.pop_front(); total++;
        if (got.x !== 0 || got.y !== 0 || got.fr !== held || got !== e) begin
            bad++; $display("FAIL restart_mid got(%s) exp(%s) held=%0d", fmt(got), fmt(e), held);
        end
        for (int i = 0; i < 2 * FRAME_CLK && found == 0; i++) begin
            clock_step(); void'(exp_q.pop_front());
            cur = model(cyc, fbase);
            if (cur.pt && cur.x == CW'(HT - 1) && cur.y == CW'(VT - 1)) found = 1;
        end
        total++; if (found !== 1) begin bad++; $display("FAIL restart_wrap_search got=%0d exp=1", found); end
        held = cur.fr;
        restart = 1'b1; clock_step(); restart = 1'b0;
        got = observe(); e = exp_q.pop_front(); total++;
        if (got.fr !== held || got !== e) begin
            bad++; $display("FAIL restart_at_wrap got(%s) exp(%s) held=%0d", fmt(got), fmt(e), held);
        end
        for (int i = 1; i <= FRAME_CLK + PD * 4; i++) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL restart_post cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
            if (frame_start && first_fs < 0) first_fs = i;
            else if (frame_start && second_fs < 0) second_fs = i;
        end
        total++;
        if (second_fs - first_fs !== FRAME_CLK || first_fs < 0) begin
            bad++; $display("FAIL restart_frame_period got=%0d exp=%0d", second_fs - first_fs, FRAME_CLK);
        end
    endtask

    task automatic test_restart_with_reset();
        obs_t got, e;
        repeat (PD * 20 + 1) clock_step();
        exp_q.delete();
        #2 restart = 1'b1; reset = 1'b1;
        #1 got = observe(); total++;
        if (got !== RESET_OBS) begin
            bad++; $display("FAIL restart_with_reset got(%s) exp(%s)", fmt(got), fmt(RESET_OBS));
        end
        @(negedge clk); reset = 1'b0; restart = 1'b0; cyc = 0; fbase = 0;
        repeat (PD * (HT + 3)) begin
            clock_step();
            got = observe(); e = exp_q.pop_front(); total++;
            if (got !== e) begin
                bad++; $display("FAIL after_reset cyc=%0d got(%s) exp(%s)", cyc, fmt(got), fmt(e));
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; fbase = 0;
        reset = 1'b1; restart = 1'b0;
        test_reset();
        test_raster();
        test_frame_wrap();
        test_restart();
        test_restart_with_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
